// File: rtl/gray_pkg.sv
// Shared constants and elaboration-time helpers for the Gray/binary codec pipeline.
package gray_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Pipeline stage that computes prefix-XOR level j, spreading L levels over PIPE stages.
  function automatic int stage_of_level(input int j, input int l, input int pipe);
    return (j * pipe) / l;
  endfunction

  // Bitmask of the prefix levels that land in stage s.
  function automatic logic [31:0] levels_in_stage(input int s, input int l, input int pipe);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < l; j++) begin
      if (stage_of_level(j, l, pipe) == s) m[j] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One register slice of the codec pipeline: valid/mode/data flops with an enable
// derived from the downstream advance, plus the prefix-XOR levels assigned to it.
module gray_pipe_stage
  import gray_pkg::*;
#(
  parameter int          DWID     = 16,
  parameter int          NCH      = 1,
  parameter logic [31:0] LVL_MASK = '0,
  parameter bit          B2G_EN   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_mode,
  input  logic [NCH*DWID-1:0]  i_data,
  input  logic                 i_adv_next,
  output logic                 o_valid,
  output logic                 o_mode,
  output logic [NCH*DWID-1:0]  o_data
);

  localparam int L = clog2(DWID);

  logic                r_valid;
  logic                r_mode;
  logic [NCH*DWID-1:0] r_data;
  logic [NCH*DWID-1:0] w_conv;
  logic [DWID-1:0]     w_ch;
  logic                w_adv;

  // An empty slot can always take a beat; a full one only if its beat moves on.
  assign w_adv = !r_valid || i_adv_next;

  // Per-channel conversion work for this slice; shifts never cross channel boundaries.
  always_comb begin
    w_conv = i_data;
    w_ch   = '0;
    for (int c = 0; c < NCH; c++) begin
      w_ch = i_data[c*DWID +: DWID];
      if (i_mode == MODE_B2G) begin
        if (B2G_EN) w_ch = w_ch ^ (w_ch >> 1);
      end else begin
        for (int j = 0; j < L; j++) begin
          if (LVL_MASK[j]) w_ch = w_ch ^ (w_ch >> (1 << j));
        end
      end
      w_conv[c*DWID +: DWID] = w_ch;
    end
  end

  // Slice registers load only on advance; data/mode load only with a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_mode  <= 1'b0;
      r_data  <= '0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_mode <= i_mode;
        r_data <= w_conv;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_mode  = r_mode;
  assign o_data  = r_data;

endmodule

// File: rtl/gray_codec_pipe.sv
// Multi-channel Gray<->binary converter, PIPE register stages deep, valid/ready
// on both sides with full throughput. Mode rides along with each beat.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int DWID = 16,
  parameter int NCH  = 1,
  parameter int PIPE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_mode,
  input  logic [NCH*DWID-1:0]  i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_mode,
  output logic [NCH*DWID-1:0]  o_data,
  output logic                 o_busy
);

  localparam int W = NCH * DWID;
  localparam int L = clog2(DWID);

  logic          w_valid [PIPE+1];
  logic          w_mode  [PIPE+1];
  logic [W-1:0]  w_data  [PIPE+1];
  logic [PIPE-1:0] w_vbits;

  assign w_valid[0] = i_valid;
  assign w_mode[0]  = i_mode;
  assign w_data[0]  = i_data;

  // The advance chain (stage s moves if empty or s+1 moves) is flattened to
  // "downstream ready, or any slot at or after s+1 empty" so no net feeds itself.
  for (genvar s = 0; s < PIPE; s++) begin : g_stage
    logic w_adv_next;

    if (s == PIPE - 1) begin : g_last
      assign w_adv_next = i_ready;
    end else begin : g_mid
      assign w_adv_next = i_ready | ~(&w_vbits[PIPE-1:s+1]);
    end

    gray_pipe_stage #(
      .DWID     (DWID),
      .NCH      (NCH),
      .LVL_MASK (levels_in_stage(s, L, PIPE)),
      .B2G_EN   (s == 0)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (w_valid[s]),
      .i_mode     (w_mode[s]),
      .i_data     (w_data[s]),
      .i_adv_next (w_adv_next),
      .o_valid    (w_valid[s+1]),
      .o_mode     (w_mode[s+1]),
      .o_data     (w_data[s+1])
    );

    assign w_vbits[s] = w_valid[s+1];
  end

  assign o_ready = i_ready | ~(&w_vbits);
  assign o_valid = w_valid[PIPE];
  assign o_mode  = w_mode[PIPE];
  assign o_data  = w_data[PIPE];
  assign o_busy  = |w_vbits;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Bench for gray_codec_pipe: several parameter sets side by side, each with a
// scoreboard fed at input handshakes and drained by a monitor at output handshakes.
module tb_gray_codec_pipe;

  localparam int NI = 8;
  localparam int P_DW [NI] = '{4, 16, 8, 8, 8, 16, 2, 5};
  localparam int P_NC [NI] = '{1,  1, 4, 1, 1,  1, 3, 2};
  localparam int P_PP [NI] = '{2,  2, 2, 1, 4,  5, 2, 3};

  typedef struct packed {
    logic [31:0] d;
    logic        m;
    int          cyc;
    logic        strict;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        iv   [NI];
  logic        im   [NI];
  logic        ir   [NI];
  logic [31:0] id   [NI];
  logic        ov   [NI];
  logic        om   [NI];
  logic        ordy [NI];
  logic        ob   [NI];
  logic [31:0] od   [NI];

  exp_t        q [NI][$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        strict  = 1'b0;
  logic        prev_stall [NI];
  logic [31:0] prev_d [NI];
  logic        prev_m [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int W = P_DW[k] * P_NC[k];
    logic [W-1:0] w_od;
    gray_codec_pipe #(.DWID(P_DW[k]), .NCH(P_NC[k]), .PIPE(P_PP[k])) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (iv[k]),
      .o_ready (ordy[k]),
      .i_mode  (im[k]),
      .i_data  (id[k][W-1:0]),
      .o_valid (ov[k]),
      .i_ready (ir[k]),
      .o_mode  (om[k]),
      .o_data  (w_od),
      .o_busy  (ob[k])
    );
    assign od[k] = 32'(w_od);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: binary bit i is the XOR of Gray bits i..MSB; Gray bit i is b[i]^b[i+1].
  function automatic logic [31:0] model(input logic [31:0] d, input logic m, input int dw, input int nch);
    logic [31:0] r;
    logic        b;
    r = '0;
    for (int c = 0; c < nch; c++) begin
      for (int i = 0; i < dw; i++) begin
        if (m == 1'b0) begin
          b = 1'b0;
          for (int t = i; t < dw; t++) b = b ^ d[c*dw + t];
        end else begin
          b = d[c*dw + i];
          if (i < dw - 1) b = b ^ d[c*dw + i + 1];
        end
        r[c*dw + i] = b;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  // Scoreboard push on input handshake, pop/compare on output handshake, stall stability.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        q[k].delete();
        prev_stall[k] = 1'b0;
      end else begin
        if (prev_stall[k]) begin
          chk("stall_valid", k, 32'(ov[k]), 32'd1);
          chk("stall_data", k, od[k], prev_d[k]);
          chk("stall_mode", k, 32'(om[k]), 32'(prev_m[k]));
        end
        if (iv[k] && ordy[k]) begin
          e.d      = model(id[k], im[k], P_DW[k], P_NC[k]);
          e.m      = im[k];
          e.cyc    = cyc;
          e.strict = strict;
          q[k].push_back(e);
        end
        if (ov[k] && ir[k]) begin
          if (q[k].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out dut%0d: got beat %h, expected no beat", k, od[k]);
          end else begin
            e = q[k].pop_front();
            chk("data", k, od[k], e.d);
            chk("mode", k, 32'(om[k]), 32'(e.m));
            if (e.strict) chk("latency", k, 32'(cyc - e.cyc), 32'(P_PP[k]));
            else          chk("min_latency", k, 32'((cyc - e.cyc) >= P_PP[k]), 32'd1);
          end
        end
        prev_stall[k] = ov[k] && !ir[k];
        prev_d[k]     = od[k];
        prev_m[k]     = om[k];
      end
    end
  end

  task automatic dir_beat(input int k, input logic m, input logic [31:0] d, input logic [31:0] expv, input string name);
    @(posedge clk); #1;
    iv[k] = 1'b1; im[k] = m; id[k] = d;
    @(negedge clk);
    chk({name, "_rdy"}, k, 32'(ordy[k]), 32'd1);
    @(posedge clk); #1;
    iv[k] = 1'b0;
    repeat (P_PP[k] - 1) @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, k, 32'(ov[k]), 32'd1);
    chk({name, "_data"}, k, od[k], expv);
    chk({name, "_mode"}, k, 32'(om[k]), 32'(m));
  endtask

  task automatic drain_check(input string name);
    for (int k = 0; k < NI; k++) iv[k] = 1'b0;
    for (int k = 0; k < NI; k++) ir[k] = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk({name, "_left"}, k, 32'(q[k].size()), 32'd0);
      chk({name, "_busy"}, k, 32'(ob[k]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0; im[k] = 1'b0; ir[k] = 1'b1; id[k] = '0;
      prev_stall[k] = 1'b0; prev_d[k] = '0; prev_m[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_valid", k, 32'(ov[k]), 32'd0);
      chk("rst_busy", k, 32'(ob[k]), 32'd0);
      chk("rst_data", k, od[k], 32'd0);
      chk("rst_mode", k, 32'(om[k]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk("post_rst_ready", k, 32'(ordy[k]), 32'd1);

    // Directed vectors, latency must be exact.
    strict = 1'b1;
    dir_beat(0, 1'b0, 32'h6, 32'h4, "t1");
    dir_beat(1, 1'b0, 32'h8000, 32'hFFFF, "t2a");
    dir_beat(1, 1'b1, 32'hFFFF, 32'h8000, "t2b");
    dir_beat(2, 1'b0, 32'h8001_03FF, 32'hFF01_02AA, "t3");

    // Continuous stream of Gray codes 0..255 must decode in order, one per clock.
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      for (int k = 3; k <= 4; k++) begin
        iv[k] = 1'b1; im[k] = 1'b0; id[k] = 32'(i ^ (i >> 1));
      end
      @(negedge clk);
      chk("stream_rdy", 3, 32'(ordy[3]), 32'd1);
      chk("stream_rdy", 4, 32'(ordy[4]), 32'd1);
    end
    drain_check("stream");

    // Fill against a blocked output: ready stays high for exactly PIPE accepted beats.
    strict = 1'b0;
    for (int k = 4; k <= 5; k++) ir[k] = 1'b0;
    for (int t = 0; t < 7; t++) begin
      @(posedge clk); #1;
      for (int k = 4; k <= 5; k++) begin
        iv[k] = 1'b1; im[k] = 1'($urandom_range(0, 1)); id[k] = $urandom;
      end
      @(negedge clk);
      for (int k = 4; k <= 5; k++) chk("fill_rdy", k, 32'(ordy[k]), 32'(t < P_PP[k]));
    end
    // Full pipe with downstream ready: in and out together, no bubble.
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      for (int k = 4; k <= 5; k++) begin
        ir[k] = 1'b1; iv[k] = 1'b1; im[k] = 1'($urandom_range(0, 1)); id[k] = $urandom;
      end
      @(negedge clk);
      for (int k = 4; k <= 5; k++) chk("full_pass_rdy", k, 32'(ordy[k]), 32'd1);
    end
    // Mid-stream 5-cycle stall.
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      for (int k = 4; k <= 5; k++) begin
        ir[k] = 1'b0; iv[k] = 1'b1; id[k] = $urandom;
      end
    end
    @(negedge clk);
    for (int k = 4; k <= 5; k++) chk("stall_rdy", k, 32'(ordy[k]), 32'd0);
    drain_check("stall");

    // Reset with two beats in flight.
    strict = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      iv[5] = 1'b1; im[5] = 1'b0; id[5] = $urandom;
    end
    @(posedge clk); #1;
    iv[5] = 1'b0;
    chk("inflight_busy", 5, 32'(ob[5]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 5, 32'(ov[5]), 32'd0);
    chk("mid_rst_busy", 5, 32'(ob[5]), 32'd0);
    chk("mid_rst_data", 5, od[5], 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 5, 32'(ordy[5]), 32'd1);
    dir_beat(5, 1'b1, 32'h1234, 32'h1B2E, "t6");
    drain_check("reset");

    // Random traffic on every parameter set, with bursts of heavy back-pressure.
    strict = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        iv[k] = ($urandom_range(0, 3) != 0);
        im[k] = 1'($urandom_range(0, 1));
        id[k] = $urandom;
        ir[k] = ($urandom_range(0, 9) < (((t / 50) % 2 == 1) ? 3 : 9));
      end
    end
    drain_check("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
